// File: rtl/uart_pkg.sv
// Shared constants for the UART TX arbiter slice: FSM encodings, header nibble, requester limit.
package uart_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;
    localparam int         MAX_REQ    = 16;

    function automatic logic [7:0] hdrByte(input logic [3:0] id);
        return {HDR_NIBBLE, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder: scans iReq from iPtr upward, wrapping, one-hot result.
// Zero latency; no flow control of its own.
module rr_pick #(
    parameter int pN = 4,
    parameter int pW = $clog2(pN)
) (
    input  logic [pN-1:0] iReq,
    input  logic [pW-1:0] iPtr,
    output logic [pN-1:0] oOneHot,
    output logic [pW-1:0] oIdx,
    output logic          oFound
);

    logic [pW:0] k;

    always_comb begin
        oOneHot = '0;
        oIdx    = '0;
        oFound  = 1'b0;
        k       = '0;
        for (int i = 0; i < pN; i++) begin
            // One spare bit so ptr + i never overflows before the wrap.
            k = {1'b0, iPtr} + (pW + 1)'(i);
            if (k >= (pW + 1)'(pN)) begin
                k = k - (pW + 1)'(pN);
            end
            if (!oFound && iReq[k[pW-1:0]]) begin
                oFound               = 1'b1;
                oIdx                 = k[pW-1:0];
                oOneHot[k[pW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter feeding the UART TX read port, with optional source-ID header.
// First byte readable two cycles after grant; the granted requester is held off only while the hold byte is unread.
module uart_tx_arbiter #(
    parameter int pNumReq   = 4,
    parameter bit pHeaderEn = 1'b1,
    parameter int pTimeout  = 1024
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [pNumReq-1:0]     iReqValid,
    input  logic [pNumReq-1:0]     iReqLast,
    input  logic [8*pNumReq-1:0]   iReqData,
    output logic [pNumReq-1:0]     oReqReady,
    output logic                   oTxRdEmpty,
    input  logic                   iTxRdEn,
    output logic [7:0]             oTxData,
    output logic [pNumReq-1:0]     oGrant,
    output logic                   oAbort
);

    import uart_pkg::*;

    localparam int pIdW = $clog2(pNumReq);

    logic [1:0]         state;
    logic [pIdW-1:0]    ptr;
    logic [pIdW-1:0]    gId;
    logic [pNumReq-1:0] grantQ;
    logic               holdValid;
    logic [7:0]         hold;
    logic [31:0]        stallCnt;

    logic [pNumReq-1:0] pickOneHot;
    logic [pIdW-1:0]    pickIdx;
    logic               pickFound;

    logic               holdFree;
    logic               txRead;
    logic               inData;
    logic               selValid;
    logic               selLast;
    logic [7:0]         selData;
    logic               accept;
    logic               stall;
    logic               timeoutHit;
    logic               loadHdr;
    logic [pIdW-1:0]    nextPtr;

    rr_pick #(
        .pN (pNumReq),
        .pW (pIdW)
    ) uRrPick (
        .iReq    (iReqValid),
        .iPtr    (ptr),
        .oOneHot (pickOneHot),
        .oIdx    (pickIdx),
        .oFound  (pickFound)
    );

    // The hold slot counts as free when it is empty or being read out this same cycle.
    assign holdFree   = !holdValid || iTxRdEn;
    assign txRead     = iTxRdEn && holdValid;
    assign inData     = (state == S_DATA);

    assign selValid   = iReqValid[gId];
    assign selLast    = iReqLast[gId];
    assign selData    = iReqData[{gId, 3'b000} +: 8];

    assign accept     = inData && holdFree && selValid;
    assign stall      = inData && holdFree && !selValid;
    assign timeoutHit = (pTimeout != 0) && stall && (stallCnt == 32'(pTimeout - 1));
    assign loadHdr    = (state == S_HDR) && holdFree;
    assign nextPtr    = (gId == pIdW'(pNumReq - 1)) ? '0 : gId + 1'b1;

    assign oReqReady  = (inData && holdFree) ? grantQ : '0;
    assign oGrant     = grantQ;
    assign oTxRdEmpty = !holdValid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= S_IDLE;
            holdValid <= 1'b0;
            hold      <= '0;
            oTxData   <= '0;
            grantQ    <= '0;
            gId       <= '0;
            ptr       <= '0;
            stallCnt  <= '0;
            oAbort    <= 1'b0;
        end else begin
            oAbort <= 1'b0;

            if (txRead) begin
                oTxData <= hold;
            end

            if (loadHdr) begin
                hold      <= hdrByte(4'(gId));
                holdValid <= 1'b1;
            end else if (accept) begin
                hold      <= selData;
                holdValid <= 1'b1;
            end else if (txRead) begin
                holdValid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pickFound) begin
                        grantQ   <= pickOneHot;
                        gId      <= pickIdx;
                        stallCnt <= '0;
                        state    <= pHeaderEn ? S_HDR : S_DATA;
                    end
                end
                S_HDR: begin
                    if (holdFree) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        stallCnt <= '0;
                        if (selLast) begin
                            state  <= S_IDLE;
                            ptr    <= nextPtr;
                            grantQ <= '0;
                        end
                    end else if (timeoutHit) begin
                        // Abandon the stalled packet; whatever is already in hold still drains.
                        oAbort <= 1'b1;
                        state  <= S_IDLE;
                        ptr    <= nextPtr;
                        grantQ <= '0;
                    end else if (stall) begin
                        stallCnt <= stallCnt + 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized traffic against a packet-level round-robin model of the UART byte stream.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                iClk = 1'b0;
    logic                iRst;
    logic [NREQ-1:0]     iReqValid;
    logic [NREQ-1:0]     iReqLast;
    logic [8*NREQ-1:0]   iReqData;
    logic [NREQ-1:0]     oReqReady;
    logic                oTxRdEmpty;
    logic                iTxRdEn;
    logic [7:0]          oTxData;
    logic [NREQ-1:0]     oGrant;
    logic                oAbort;

    uart_tx_arbiter #(
        .pNumReq   (NREQ),
        .pHeaderEn (1'b1),
        .pTimeout  (TMO)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iReqValid  (iReqValid),
        .iReqLast   (iReqLast),
        .iReqData   (iReqData),
        .oReqReady  (oReqReady),
        .oTxRdEmpty (oTxRdEmpty),
        .iTxRdEn    (iTxRdEn),
        .oTxData    (oTxData),
        .oGrant     (oGrant),
        .oAbort     (oAbort)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Source side: bytes each requester still has to offer.
    logic [7:0]      sBytes [NREQ][$];
    logic            sLast  [NREQ][$];
    logic [NREQ-1:0] sEn;
    int              sGap   [NREQ];
    int              accCnt [NREQ];
    int              accEdge[NREQ];

    // Reference model: packets per requester and the byte stream the UART must see.
    logic [7:0]      mBytes [NREQ][$];
    int              mLen   [NREQ][$];
    int              mPtr;
    logic [7:0]      expQ[$];
    logic [7:0]      lastTx;

    int edgeCnt, abortCnt, abortEdge, readyLeak, multiGrant;
    int rdPct;
    bit gapsOn, trigOn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic openPkt(input int k);
        mLen[k].push_back(0);
    endtask

    task automatic addByte(input int k, input logic [7:0] b, input bit last);
        sBytes[k].push_back(b);
        sLast[k].push_back(last);
        mBytes[k].push_back(b);
        mLen[k][mLen[k].size() - 1] = mLen[k][mLen[k].size() - 1] + 1;
    endtask

    task automatic randPkt(input int k, input int n);
        openPkt(k);
        for (int j = 0; j < n; j++) addByte(k, 8'($urandom), j == n - 1);
    endtask

    // Packet-level round robin: next requester with a queued packet after the last one served.
    task automatic arbitrate(input logic [NREQ-1:0] mask);
        bit any;
        do begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                int k;
                int n;
                k = (mPtr + i) % NREQ;
                if (!any && mask[k] && mLen[k].size() > 0) begin
                    any = 1'b1;
                    n = mLen[k].pop_front();
                    expQ.push_back({4'hA, 4'(k)});
                    for (int j = 0; j < n; j++) expQ.push_back(mBytes[k].pop_front());
                    mPtr = (k + 1) % NREQ;
                end
            end
        end while (any);
    endtask

    function automatic bit srcBusy();
        for (int k = 0; k < NREQ; k++) if (sEn[k] && sBytes[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (sEn[k] && sBytes[k].size() > 0 && sGap[k] == 0) begin
                iReqValid[k]        = 1'b1;
                iReqData[8*k +: 8]  = sBytes[k][0];
                iReqLast[k]         = sLast[k][0];
            end else begin
                iReqValid[k]        = 1'b0;
                iReqData[8*k +: 8]  = 8'h00;
                iReqLast[k]         = 1'b0;
            end
        end
        iTxRdEn = ($urandom_range(0, 99) < rdPct);
    endtask

    task automatic step();
        logic [NREQ-1:0] fire;
        logic            rdFire;
        logic            lastFlag;
        logic [7:0]      exp;
        @(negedge iClk);
        if ((oReqReady & ~oGrant) != '0) readyLeak++;
        if ($countones(oGrant) > 1) multiGrant++;
        if (oAbort) begin
            abortCnt++;
            abortEdge = edgeCnt;
        end
        fire   = iReqValid & oReqReady;
        rdFire = iTxRdEn && !oTxRdEmpty;
        @(posedge iClk);
        edgeCnt++;
        #1;
        if (rdFire) begin
            chk("tx_byte_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                chk("tx_byte", {24'h0, oTxData}, {24'h0, exp});
                lastTx = exp;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (fire[k]) begin
                lastFlag = sLast[k].pop_front();
                void'(sBytes[k].pop_front());
                accCnt[k]++;
                accEdge[k] = edgeCnt;
                sGap[k] = (!lastFlag && gapsOn && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end else if (sGap[k] > 0) begin
                sGap[k]--;
            end
        end
        if (trigOn && accCnt[1] >= 1) sEn[3] = 1'b1;
        drive();
    endtask

    task automatic runPhase(input string tag, input int budget);
        int n;
        n = 0;
        while ((expQ.size() > 0 || srcBusy()) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_in_budget"}, 32'(n < budget), 32'd1);
        repeat (4) step();
        chk({tag, "_grant_idle"}, {28'h0, oGrant}, 32'h0);
        chk({tag, "_empty_idle"}, {31'h0, oTxRdEmpty}, 32'h1);
    endtask

    task automatic clearPhase();
        for (int k = 0; k < NREQ; k++) begin
            accCnt[k] = 0;
            sGap[k]   = 0;
        end
    endtask

    initial begin
        int n;
        edgeCnt = 0; abortCnt = 0; abortEdge = 0; readyLeak = 0; multiGrant = 0;
        mPtr = 0; lastTx = 8'h00; rdPct = 0; gapsOn = 1'b0; trigOn = 1'b0; sEn = '0;
        clearPhase();
        iRst = 1'b1;
        drive();
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_empty", {31'h0, oTxRdEmpty}, 32'h1);
        chk("rst_txdata", {24'h0, oTxData}, 32'h0);
        chk("rst_ready", {28'h0, oReqReady}, 32'h0);
        chk("rst_grant", {28'h0, oGrant}, 32'h0);
        chk("rst_abort", {31'h0, oAbort}, 32'h0);
        iRst = 1'b0;

        // Single packet from requester 2.
        rdPct = 70; sEn = '1;
        openPkt(2);
        addByte(2, 8'h11, 1'b0);
        addByte(2, 8'h22, 1'b0);
        addByte(2, 8'h33, 1'b1);
        arbitrate('1);
        runPhase("single", 200);

        // Round robin between two continuously pending requesters.
        for (int p = 0; p < 2; p++) begin
            randPkt(0, 2);
            randPkt(1, 2);
        end
        arbitrate('1);
        runPhase("rr", 400);

        // Requester 3 turns up while requester 1's packet is open.
        clearPhase();
        readyLeak = 0; multiGrant = 0;
        sEn = 4'b0111; trigOn = 1'b1; rdPct = 50;
        randPkt(1, 4);
        randPkt(3, 2);
        arbitrate(4'b0010);
        arbitrate(4'b1000);
        runPhase("atomic", 400);
        trigOn = 1'b0; sEn = '1;
        chk("atomic_ready_leak", 32'(readyLeak), 32'd0);
        chk("atomic_multi_grant", 32'(multiGrant), 32'd0);

        // Requester 0 stalls after one byte; requester 1 waits behind it.
        clearPhase();
        abortCnt = 0; rdPct = 100; gapsOn = 1'b0;
        openPkt(0);
        addByte(0, 8'($urandom), 1'b0);
        randPkt(1, 3);
        arbitrate('1);
        runPhase("timeout", 400);
        chk("abort_pulses", 32'(abortCnt), 32'd1);
        chk("abort_delay", 32'(abortEdge - accEdge[0]), 32'(TMO));

        // UART reads while nothing is held.
        repeat (3) step();
        chk("empty_read_data", {24'h0, oTxData}, {24'h0, lastTx});
        chk("empty_read_empty", {31'h0, oTxRdEmpty}, 32'h1);
        chk("empty_read_grant", {28'h0, oGrant}, 32'h0);

        // Reset with requester 1's header sitting unread in the hold register.
        rdPct = 0;
        for (int j = 0; j < 3; j++) begin
            sBytes[1].push_back(8'($urandom));
            sLast[1].push_back(j == 2);
        end
        n = 0;
        while (oTxRdEmpty && n < 20) begin
            step();
            n++;
        end
        chk("hdr_loaded_before_reset", {31'h0, oTxRdEmpty}, 32'h0);
        iRst = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            sBytes[k].delete();
            sLast[k].delete();
        end
        step();
        chk("midrst_empty", {31'h0, oTxRdEmpty}, 32'h1);
        chk("midrst_txdata", {24'h0, oTxData}, 32'h0);
        chk("midrst_grant", {28'h0, oGrant}, 32'h0);
        chk("midrst_ready", {28'h0, oReqReady}, 32'h0);
        chk("midrst_abort", {31'h0, oAbort}, 32'h0);
        iRst = 1'b0;
        mPtr = 0;
        rdPct = 100;
        repeat (6) step();
        chk("midrst_no_header", {31'h0, oTxRdEmpty}, 32'h1);
        // Both pending: a pointer back at 0 serves requester 1 before 3.
        clearPhase();
        rdPct = 60;
        randPkt(3, 2);
        randPkt(1, 2);
        arbitrate('1);
        runPhase("ptr_after_reset", 300);

        // Random traffic with read gaps and mid-packet valid gaps.
        gapsOn = 1'b1;
        for (int r = 0; r < 4; r++) begin
            clearPhase();
            readyLeak = 0; multiGrant = 0; abortCnt = 0;
            rdPct = int'($urandom_range(30, 95));
            for (int k = 0; k < NREQ; k++) begin
                n = int'($urandom_range(0, 2));
                for (int p = 0; p < n; p++) randPkt(k, int'($urandom_range(1, 5)));
            end
            arbitrate('1);
            runPhase("random", 3000);
            chk("random_ready_leak", 32'(readyLeak), 32'd0);
            chk("random_multi_grant", 32'(multiGrant), 32'd0);
            chk("random_no_abort", 32'(abortCnt), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
